// File: rtl/aes_cipher_txt_arbiter_pkg.sv
// Shared types, widths and the round-robin search helper for the cipher-text arbiter.
//   aes_block_t : one 128-bit AES state, [127:120] = row0/col0 ... [7:0] = row3/col3
//   rr_next()   : index of the first set request after 'owner', wrapping, owner checked last
package aes_arb_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int unsigned BLK_CNT_W   = 16;
  localparam int unsigned BURST_CNT_W = 4;

  // Largest supported requester count and the index width that covers it.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  // Rotated-priority search: owner+1, owner+2, ... wrapping modulo num_req.
  // Returns owner when nothing is requesting; callers qualify with |req.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   owner,
                                               input int unsigned        num_req);
    logic [IDX_W-1:0] win;
    logic             hit;
    int unsigned      idx;
    win = owner;
    hit = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(owner) + k) % num_req;
      if (k <= num_req && !hit && req[idx[IDX_W-1:0]]) begin
        win = idx[IDX_W-1:0];
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/aes_cipher_txt_arbiter_if.sv
// Valid/ready block stream with a source tag, used toward the encryptor output buffer.
//   vld  : block valid          data : 128-bit block
//   rdy  : sink ready           src  : index of the producing core
interface aes_cipher_txt_arbiter_if
  import aes_arb_pkg::*;
#(
  parameter int unsigned SRC_W = 2
) ();

  logic             vld;
  logic             rdy;
  aes_block_t       data;
  logic [SRC_W-1:0] src;

  modport master (
    output vld,
    output data,
    output src,
    input  rdy
  );

  modport slave (
    input  vld,
    input  data,
    input  src,
    output rdy
  );

endinterface

// File: rtl/aes_cipher_txt_arbiter_picker.sv
// Purely combinational rotate-and-find-first.
//   req       : request vector
//   start_idx : highest-priority slot for this search
//   gnt_idx   : first set slot at or after start_idx, wrapping
//   found     : any request set
module aes_rr_picker
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   start_idx,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   win;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    // rr_next searches after its owner argument, so pass the slot just before start_idx.
    if (start_idx == '0) begin
      last_idx = IDX_W'(NUM_REQ - 1);
    end else begin
      last_idx = IDX_W'(start_idx - SRC_W'(1));
    end
    win     = rr_next(req_ext, last_idx, NUM_REQ);
    gnt_idx = SRC_W'(win);
    found   = |req;
  end

endmodule

// File: rtl/aes_cipher_txt_arbiter.sv
// Round-robin arbiter sharing the cipher-text write port among NUM_REQ AES cores.
// Each core may take up to MAX_BURST consecutive grants while others wait; accepted
// blocks go through one output register tagged with their source index.
//   aes_clk, resetn : clock, asynchronous active-low reset
//   arb_en          : allow new grants (output register still drains when low)
//   req_vld/rdy/data: per-core block handshake, req_rdy one-hot or zero
//   buf_if          : registered block stream toward the output buffer
//   blk_cnt         : blocks delivered downstream, wrapping
//   busy            : block held or any request pending
module aes_cipher_txt_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 2,
  parameter int unsigned SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                       aes_clk,
  input  logic                       resetn,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  aes_block_t [NUM_REQ-1:0]   req_data,
  aes_cipher_txt_arbiter_if.master   buf_if,
  output logic [BLK_CNT_W-1:0]       blk_cnt,
  output logic                       busy
);

  localparam logic [BURST_CNT_W-1:0] MaxBurst = BURST_CNT_W'(MAX_BURST);
  localparam logic [SRC_W-1:0]       LastIdx  = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]       owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   buf_vld_q, buf_vld_d;
  aes_block_t             buf_data_q, buf_data_d;
  logic [SRC_W-1:0]       buf_src_q, buf_src_d;
  logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic [SRC_W-1:0] start_idx;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_found;
  logic             keep;
  logic             loadable;
  logic             xfer;
  logic             deliver;
  logic [SRC_W-1:0] winner;

  assign start_idx = (owner_q == LastIdx) ? '0 : owner_q + SRC_W'(1);

  aes_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_picker (
    .req       (req_vld),
    .start_idx (start_idx),
    .gnt_idx   (pick_idx),
    .found     (pick_found)
  );

  // burst_cnt == 0 only after reset: no owner yet, so the search decides (core 0 first).
  assign keep     = req_vld[owner_q] && (burst_cnt_q != '0) && (burst_cnt_q < MaxBurst);
  assign loadable = resetn & arb_en & (~buf_vld_q | buf_if.rdy);
  assign xfer     = loadable & (keep | pick_found);
  assign winner   = keep ? owner_q : pick_idx;
  assign deliver  = buf_vld_q & buf_if.rdy;

  always_comb begin
    req_rdy = '0;
    if (xfer) begin
      req_rdy[winner] = 1'b1;
    end
  end

  // Ownership: extending a live burst counts up, anything else (including a lone
  // requester re-found by the wrap-around search) restarts the burst at 1.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      if (keep) begin
        burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
      end else begin
        owner_d     = winner;
        burst_cnt_d = BURST_CNT_W'(1);
      end
    end
  end

  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    buf_src_d  = buf_src_q;
    if (xfer) begin
      buf_vld_d  = 1'b1;
      buf_data_d = req_data[winner];
      buf_src_d  = winner;
    end else if (buf_if.rdy) begin
      buf_vld_d  = 1'b0;
    end
  end

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (deliver) begin
      blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
    end
  end

  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      owner_q     <= LastIdx;
      burst_cnt_q <= '0;
      buf_vld_q   <= 1'b0;
      buf_data_q  <= '0;
      buf_src_q   <= '0;
      blk_cnt_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      buf_vld_q   <= buf_vld_d;
      buf_data_q  <= buf_data_d;
      buf_src_q   <= buf_src_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign buf_if.vld  = buf_vld_q;
  assign buf_if.data = buf_data_q;
  assign buf_if.src  = buf_src_q;
  assign blk_cnt     = blk_cnt_q;
  assign busy        = buf_vld_q | (|req_vld);

endmodule

// File: tb/tb_aes_cipher_txt_arbiter.sv
// Bench for aes_cipher_txt_arbiter: directed scenarios with literal expectations, then
// randomized requesters; a behavioural model is compared against the DUT every cycle.
module tb_aes_cipher_txt_arbiter;

  localparam int N         = 4;
  localparam int MAX_BURST = 2;

  logic             aes_clk;
  logic             resetn;
  logic             arb_en;
  logic [N-1:0]     req_vld;
  logic [N-1:0]     req_rdy;
  logic [N-1:0][127:0] req_data;
  logic             buf_rdy;
  logic             buf_vld;
  logic [127:0]     buf_data;
  logic [1:0]       buf_src;
  logic [15:0]      blk_cnt;
  logic             busy;

  aes_cipher_txt_arbiter_if #(.SRC_W(2)) buf_if ();

  assign buf_if.rdy = buf_rdy;
  assign buf_vld    = buf_if.vld;
  assign buf_data   = buf_if.data;
  assign buf_src    = buf_if.src;

  aes_cipher_txt_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (MAX_BURST),
    .SRC_W     (2)
  ) dut (
    .aes_clk  (aes_clk),
    .resetn   (resetn),
    .arb_en   (arb_en),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .buf_if   (buf_if),
    .blk_cnt  (blk_cnt),
    .busy     (busy)
  );

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how long it has held it, what sits downstream.
  int           m_owner = N - 1;
  int           m_cnt   = 0;
  logic         m_vld   = 1'b0;
  logic [127:0] m_data  = '0;
  logic [1:0]   m_src   = '0;
  logic [15:0]  m_blk   = '0;
  logic [N-1:0] m_acc   = '0;

  function automatic bit m_keep(input logic [N-1:0] v);
    return v[m_owner] && m_cnt > 0 && m_cnt < MAX_BURST;
  endfunction

  // Winner for this cycle, or -1 when no grant may be issued.
  function automatic int m_pick(input logic [N-1:0] v);
    if (!resetn || !arb_en || (m_vld && !buf_rdy)) return -1;
    if (m_keep(v)) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  always @(negedge aes_clk) begin : cmp
    int           w;
    bit           kept;
    logic [N-1:0] exp_rdy;
    if (!resetn) begin
      m_owner = N - 1;
      m_cnt   = 0;
      m_vld   = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_blk   = '0;
    end
    w       = m_pick(req_vld);
    kept    = (w >= 0) && m_keep(req_vld);
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    m_acc   = exp_rdy;
    chk("req_rdy", 128'(req_rdy), 128'(exp_rdy));
    chk("buf_vld", 128'(buf_vld), 128'(m_vld));
    chk("buf_data", buf_data, m_data);
    chk("buf_src", 128'(buf_src), 128'(m_src));
    chk("blk_cnt", 128'(blk_cnt), 128'(m_blk));
    chk("busy", 128'(busy), 128'(m_vld | (|req_vld)));
    if (resetn) begin
      if (m_vld && buf_rdy) m_blk = m_blk + 16'd1;
      if (w >= 0) begin
        if (kept) begin
          m_cnt = m_cnt + 1;
        end else begin
          m_owner = w;
          m_cnt   = 1;
        end
        m_vld  = 1'b1;
        m_data = req_data[w];
        m_src  = 2'(w);
      end else if (buf_rdy) begin
        m_vld = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge aes_clk);
    #1;
  endtask

  int exp_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_u;
  logic [N-1:0] pend;

  initial begin
    resetn   = 1'b0;
    arb_en   = 1'b1;
    buf_rdy  = 1'b1;
    req_vld  = '0;
    req_data = '0;
    repeat (2) step();

    // Single request straight out of reset.
    req_vld     = 4'b0001;
    req_data[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    resetn      = 1'b1;
    #1 chk("t1_rdy", 128'(req_rdy), 128'(4'b0001));
    step();
    req_vld = '0;
    chk("t1_vld", 128'(buf_vld), 128'd1);
    chk("t1_src", 128'(buf_src), 128'd0);
    chk("t1_data", buf_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    step();
    chk("t1_cnt", 128'(blk_cnt), 128'd1);

    // All cores requesting continuously: bursts of two, rotating.
    resetn = 1'b0;
    step();
    for (int i = 0; i < N; i++) req_data[i] = {4{32'(i + 16)}};
    req_vld = 4'b1111;
    resetn  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_src", 128'(buf_src), 128'(exp_seq[k]));
    end
    step();
    chk("t2_cnt", 128'(blk_cnt), 128'd10);
    req_vld = '0;

    // Lone core 2: five back-to-back blocks with no bubble across the burst limit.
    for (int k = 0; k < 5; k++) begin
      blk_u       = {$urandom, $urandom, $urandom, $urandom};
      req_data[2] = blk_u;
      req_vld     = 4'b0100;
      #1 chk("t3_rdy", 128'(req_rdy), 128'(4'b0100));
      step();
      chk("t3_vld", 128'(buf_vld), 128'd1);
      chk("t3_src", 128'(buf_src), 128'd2);
      chk("t3_data", buf_data, blk_u);
    end
    req_vld = '0;

    // Downstream stall holds the register and blocks grants.
    blk_a       = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    blk_b       = 128'h5A5A_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    req_data[0] = blk_a;
    req_vld     = 4'b0001;
    step();
    req_data[1] = blk_b;
    req_vld     = 4'b0010;
    buf_rdy     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_rdy", 128'(req_rdy), 128'd0);
      chk("t4_data", buf_data, blk_a);
      chk("t4_src", 128'(buf_src), 128'd0);
      step();
    end
    buf_rdy = 1'b1;
    #1 chk("t4_rdy_back", 128'(req_rdy), 128'(4'b0010));
    step();
    req_vld = '0;
    chk("t4_data_b", buf_data, blk_b);
    chk("t4_src_b", 128'(buf_src), 128'd1);

    // arb_en low: held block drains, nothing new is granted.
    blk_c       = 128'hC0C0_C0C0_0102_0304_0506_0708_090A_0B0C;
    blk_d       = 128'hD0D0_D0D0_F1F2_F3F4_F5F6_F7F8_F9FA_FBFC;
    req_data[0] = blk_c;
    req_vld     = 4'b0001;
    step();
    req_data[0] = blk_d;
    arb_en      = 1'b0;
    #1 chk("t5_rdy0", 128'(req_rdy), 128'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t5_vld", 128'(buf_vld), 128'd0);
      chk("t5_rdy", 128'(req_rdy), 128'd0);
    end
    arb_en = 1'b1;
    #1 chk("t5_rdy_en", 128'(req_rdy), 128'(4'b0001));
    step();
    req_vld = '0;
    chk("t5_data", buf_data, blk_d);

    // Reset mid-stream with blk_cnt = 7 and a block held.
    resetn = 1'b0;
    step();
    req_vld = 4'b1000;
    resetn  = 1'b1;
    repeat (8) step();
    chk("t6_pre_cnt", 128'(blk_cnt), 128'd7);
    chk("t6_pre_vld", 128'(buf_vld), 128'd1);
    req_vld = 4'b1001;
    resetn  = 1'b0;
    #1;
    chk("t6_vld", 128'(buf_vld), 128'd0);
    chk("t6_cnt", 128'(blk_cnt), 128'd0);
    chk("t6_rdy", 128'(req_rdy), 128'd0);
    chk("t6_busy", 128'(busy), 128'd1);
    step();
    resetn = 1'b1;
    #1 chk("t6_rdy_rel", 128'(req_rdy), 128'(4'b0001));
    step();
    chk("t6_src", 128'(buf_src), 128'd0);
    req_vld = '0;

    // Randomized requesters that hold each block until the model says it was taken.
    pend = '0;
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          req_data[i] = {$urandom, $urandom, $urandom, $urandom};
          pend[i]     = 1'b1;
        end
      end
      req_vld = pend;
      buf_rdy = ($urandom_range(0, 9) < 7);
      arb_en  = ($urandom_range(0, 15) != 0);
      resetn  = !(resetn && $urandom_range(0, 599) == 0);
    end
    resetn = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
